// File: rtl/arb_pkg.sv
// Shared types and constants for the request arbiter.
package arb_pkg;

  // Arbiter FSM states: waiting for requests, serving one owner, turnaround gap.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_t;

  // Values of the rr_mode input.
  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: highest-index-wins fixed priority, or
// round-robin searching downward from just below the last owner.
module arb_pick
  import arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] rr_ptr,
  input  logic            rr_mode,
  output logic [N-1:0]    win_onehot,
  output logic [ID_W-1:0] win_id,
  output logic            any
);

  // Priority-encode req; the round-robin search wraps from index 0 to N-1.
  always_comb begin
    logic found;
    int   idx;
    // NOTE: every output gets a default before any branch so no latch is inferred.
    win_onehot = '0;
    win_id     = '0;
    any        = |req;
    found      = 1'b0;
    idx        = 0;
    if (rr_mode == ARB_RR) begin
      // Offsets 1..N visit rr_ptr-1, rr_ptr-2, ... and finally rr_ptr itself.
      for (int i = 1; i <= N; i++) begin
        idx = (int'(rr_ptr) + N - i) % N;
        if (!found && req[idx]) begin
          found  = 1'b1;
          win_id = ID_W'(idx);
        end
      end
    end else begin
      // Ascending scan: the last set bit seen is the highest index.
      for (int i = 0; i < N; i++) begin
        if (req[i]) win_id = ID_W'(i);
      end
    end
    if (any) win_onehot[win_id] = 1'b1;
  end

endmodule

// File: rtl/req_arbiter.sv
// Registered request/grant arbiter for N requesters with an owner hold limit
// and a one-cycle turnaround gap between consecutive grants.
module req_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            rr_mode,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_valid,
  output logic            timeout
);

  // Counter wide enough to hold MAX_HOLD-1, at least one bit.
  localparam int                HOLD_W    = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N-1:0]      gnt_d;
  logic [ID_W-1:0]   gnt_id_d;
  logic              timeout_d;

  logic [N-1:0]      win_onehot;
  logic [ID_W-1:0]   win_id;
  logic              any;

  arb_pick #(
    .N    (N),
    .ID_W (ID_W)
  ) u_pick (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .rr_mode    (rr_mode),
    .win_onehot (win_onehot),
    .win_id     (win_id),
    .any        (any)
  );

  assign gnt_valid = |gnt;

  // Next-state and next-output logic for the IDLE/GRANT/GAP cycle.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt;
    gnt_id_d  = gnt_id;
    timeout_d = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (en && any) begin
          gnt_d    = win_onehot;
          gnt_id_d = win_id;
          rr_ptr_d = win_id;
          hold_d   = '0;
          state_d  = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        // A voluntary release takes precedence over the hold limit.
        if (!req[gnt_id]) begin
          gnt_d   = '0;
          hold_d  = '0;
          state_d = ARB_GAP;
        end else if (hold_q == HOLD_LAST) begin
          gnt_d     = '0;
          hold_d    = '0;
          timeout_d = 1'b1;
          state_d   = ARB_GAP;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ARB_GAP: begin
        hold_d  = '0;
        state_d = ARB_IDLE;
      end
      default: begin
        gnt_d   = '0;
        hold_d  = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State, counter, pointer and registered outputs; async reset clears all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      hold_q   <= '0;
      rr_ptr_q <= ID_W'(N - 1);
      gnt      <= '0;
      gnt_id   <= '0;
      timeout  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      hold_q   <= hold_d;
      rr_ptr_q <= rr_ptr_d;
      gnt      <= gnt_d;
      gnt_id   <= gnt_id_d;
      timeout  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_req_arbiter.sv
// Directed self-checking bench for req_arbiter (N=4, MAX_HOLD=8).
module tb_req_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rr_mode;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  req_arbiter #(
    .N        (4),
    .MAX_HOLD (8),
    .ID_W     (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rr_mode   (rr_mode),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  // Advance to just after the next rising edge; outputs are stable there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; rr_mode = 1'b0; req = 4'b0000;
    tick(); tick();
    checks++;
    if ({gnt, gnt_id, gnt_valid, timeout} !== 8'b0000_00_0_0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp %b", {gnt, gnt_id, gnt_valid, timeout}, 8'b0000_00_0_0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({gnt, gnt_valid, timeout} !== 6'b0000_0_0) begin
      errors++;
      $display("FAIL reset_idle got %b exp %b", {gnt, gnt_valid, timeout}, 6'b0000_0_0);
    end
  endtask

  task automatic test_fixed();
    rr_mode = 1'b0;
    req = 4'b0101;
    tick();
    checks++;
    if ({gnt, gnt_id, gnt_valid, timeout} !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fixed_first got %b exp %b", {gnt, gnt_id, gnt_valid, timeout}, {4'b0100, 2'd2, 1'b1, 1'b0});
    end
    req = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({gnt, gnt_valid, timeout} !== 6'b0000_0_0) begin
        errors++;
        $display("FAIL fixed_gap%0d got %b exp %b", i, {gnt, gnt_valid, timeout}, 6'b0000_0_0);
      end
    end
    tick();
    checks++;
    if ({gnt, gnt_id, gnt_valid, timeout} !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fixed_second got %b exp %b", {gnt, gnt_id, gnt_valid, timeout}, {4'b0001, 2'd0, 1'b1, 1'b0});
    end
    req = 4'b0000;
    tick(); tick();
  endtask

  // Pointer is 0 from the previous owner, so the search starts at index 3.
  task automatic test_rr();
    logic [1:0] order [5] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
    logic [3:0] oh;
    rr_mode = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      oh = 4'b0001 << order[k];
      checks++;
      if ({gnt, gnt_id, gnt_valid} !== {oh, order[k], 1'b1}) begin
        errors++;
        $display("FAIL rr_grant%0d got %b exp %b", k, {gnt, gnt_id, gnt_valid}, {oh, order[k], 1'b1});
      end
      req = 4'b1111 & ~oh;
      tick();
      checks++;
      if (gnt_valid !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap%0d got %b exp %b", k, gnt_valid, 1'b0);
      end
      req = (k == 4) ? 4'b0000 : 4'b1111;
      tick();
      checks++;
      if (gnt_valid !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle%0d got %b exp %b", k, gnt_valid, 1'b0);
      end
    end
  endtask

  task automatic test_timeout();
    rr_mode = 1'b0;
    req = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({gnt, gnt_id, timeout} !== {4'b0010, 2'd1, 1'b0}) begin
        errors++;
        $display("FAIL timeout_hold%0d got %b exp %b", i, {gnt, gnt_id, timeout}, {4'b0010, 2'd1, 1'b0});
      end
    end
    tick();
    checks++;
    if ({gnt, gnt_valid, timeout} !== 6'b0000_0_1) begin
      errors++;
      $display("FAIL timeout_pulse got %b exp %b", {gnt, gnt_valid, timeout}, 6'b0000_0_1);
    end
    tick();
    checks++;
    if ({gnt, gnt_valid, timeout} !== 6'b0000_0_0) begin
      errors++;
      $display("FAIL timeout_after got %b exp %b", {gnt, gnt_valid, timeout}, 6'b0000_0_0);
    end
    tick();
    checks++;
    if ({gnt, gnt_id, gnt_valid} !== {4'b0010, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL timeout_regrant got %b exp %b", {gnt, gnt_id, gnt_valid}, {4'b0010, 2'd1, 1'b1});
    end
  endtask

  // Continues from the re-grant (hold count 0); release lands on hold count 7.
  task automatic test_release_at_limit();
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++;
      if (gnt !== 4'b0010) begin
        errors++;
        $display("FAIL limit_hold%0d got %b exp %b", i, gnt, 4'b0010);
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if ({gnt, gnt_valid, timeout} !== 6'b0000_0_0) begin
      errors++;
      $display("FAIL limit_release got %b exp %b", {gnt, gnt_valid, timeout}, 6'b0000_0_0);
    end
    tick();
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL limit_no_pulse got %b exp %b", timeout, 1'b0);
    end
  endtask

  task automatic test_no_preempt_enable();
    rr_mode = 1'b0;
    req = 4'b0001;
    tick();
    req = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({gnt, gnt_id} !== {4'b0001, 2'd0}) begin
        errors++;
        $display("FAIL preempt%0d got %b exp %b", i, {gnt, gnt_id}, {4'b0001, 2'd0});
      end
    end
    req = 4'b1000;
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({gnt, gnt_valid} !== 5'b0000_0) begin
        errors++;
        $display("FAIL en_low%0d got %b exp %b", i, {gnt, gnt_valid}, 5'b0000_0);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if ({gnt, gnt_id, gnt_valid} !== {4'b1000, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL en_high got %b exp %b", {gnt, gnt_id, gnt_valid}, {4'b1000, 2'd3, 1'b1});
    end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_async_reset();
    rr_mode = 1'b0;
    req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL areset_pre got %b exp %b", gnt, 4'b0100);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({gnt, gnt_valid, timeout} !== 6'b0000_0_0) begin
      errors++;
      $display("FAIL areset_drop got %b exp %b", {gnt, gnt_valid, timeout}, 6'b0000_0_0);
    end
    rr_mode = 1'b1;
    req = 4'b1111;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({gnt, gnt_id, gnt_valid, timeout} !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL areset_rr_first got %b exp %b", {gnt, gnt_id, gnt_valid, timeout}, {4'b0100, 2'd2, 1'b1, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr();
    test_timeout();
    test_release_at_limit();
    test_no_preempt_enable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/req_arbiter.md
Name: req_arbiter

Overview:
- Shares one resource among N requesters using a registered request/grant handshake.
- Arbitration is fixed-priority (highest index wins, as in the existing priority encoder) or round-robin, selected at run time.
- An owner keeps its grant until it drops its request or a hold-limit timeout forces release.
- Sits in front of any shared datapath: bus, memory port or encoder input mux.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive grant cycles before forced release (>=1).
- ID_W, $clog2(N), width of the binary grant index.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  arbitration enable; when low, no new grant is issued.
- rr_mode  input  1  0 = fixed priority, 1 = round-robin; sampled only at arbitration.
- req  input  N  per-requester request, level, held until served.
- gnt  output  N  one-hot grant, registered.
- gnt_id  output  ID_W  binary index of the owner; valid only when gnt_valid=1.
- gnt_valid  output  1  high while any grant is active (equals |gnt).
- timeout  output  1  one-cycle pulse on the cycle a grant is forcibly revoked.

Behaviour:
- Reset (async, immediate): state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, hold_cnt=0, rr_ptr=N-1.
- States are IDLE, GRANT and GAP.
- IDLE: arbitration happens on each edge where en=1 and |req=1.
  - Winner is loaded into gnt and gnt_id; next state is GRANT.
  - Latency: req rising before edge k gives gnt at edge k (visible in cycle k+1). There is no combinational path from req to gnt.
- Fixed mode: the winner is the highest set index of req.
- Round-robin mode:
  - Search starts at index (rr_ptr-1) mod N and goes downward with wrap-around. The first set bit wins.
  - rr_ptr is updated to the winner index on every grant, in both modes.
  - The last owner therefore becomes lowest priority.
- GRANT: hold_cnt increments each cycle; it is 0 on the first grant cycle.
  - req[gnt_id]=0 at an edge: clear gnt and go to GAP. No timeout.
  - hold_cnt==MAX_HOLD-1 with req[gnt_id] still 1: clear gnt, timeout=1 for one cycle, go to GAP.
  - If both conditions occur on the same edge, release wins and timeout stays 0.
  - Requests from other indices are ignored while in GRANT. No preemption, even by a higher index.
  - en going low does not revoke an active grant.
- GAP: exactly one cycle with gnt=0 (bus turnaround), then IDLE. hold_cnt is cleared.
  - Minimum spacing between two grants is therefore 2 idle cycles.
  - A timed-out requester still asserting req may be re-granted at the next arbitration. In fixed mode this is expected; in RR mode others win first.
- en=0 in IDLE: stay in IDLE. Pending req are not latched; they are evaluated live once en returns.
- rr_mode changes mid-grant take effect at the next arbitration only.
- Reset asserted mid-grant: all outputs drop asynchronously. No timeout pulse is emitted.
- Invariants: gnt is zero or one-hot; gnt_valid == |gnt; gnt_id matches the gnt bit; timeout is never high in two consecutive cycles.

Decomposition:
- Shared package arb_pkg:
  - state enum {ARB_IDLE, ARB_GRANT, ARB_GAP}.
  - mode constants ARB_FIXED=1'b0, ARB_RR=1'b1.
- One sub-module, arb_pick: purely combinational winner selection.
  - Inputs: req, rr_ptr, rr_mode.
  - Outputs: win_onehot, win_id, any.
  - It wraps the priority-encode function so it can be unit-tested alone.
- The FSM, hold counter and pointer live in req_arbiter.

Test Plan:
- Fixed priority, N=4, rr_mode=0, en=1: req=4'b0101 -> gnt=4'b0100, gnt_id=2 one cycle later. Drop req[2] -> one GAP cycle with gnt=0, then gnt=4'b0001, gnt_id=0.
- Round-robin, rr_mode=1, req=4'b1111 held, each owner drops req for one cycle after 1 grant cycle -> grant order is 3,2,1,0,3; gnt_valid is never high in the GAP cycles.
- Timeout, MAX_HOLD=8, req=4'b0010 held constant -> gnt_id=1 for exactly 8 cycles, timeout pulses once, 1 GAP cycle, then re-granted to 1.
- Simultaneous release and limit: drop req[1] on the same edge hold_cnt==7 -> gnt clears and timeout stays 0.
- No preemption and enable: gnt=4'b0001 active, raise req[3] -> gnt unchanged until req[0] drops.
  - Then en=0 with req=4'b1000 -> no grant.
  - en=1 -> gnt=4'b1000 next cycle.
- Async reset mid-grant: assert rst between edges while gnt=4'b0100 -> gnt, gnt_valid and timeout go to 0 immediately.
  - After deassert in RR mode with req=4'b1111 -> first winner is 2 (rr_ptr reset value 3).
